banked_registers: RTL and testbench

Parametrised per-core register file holding one register bank per thread, sitting between the decoder and the ALU/LSU of each compute core. It adds byte-lane write masking, same-cycle write-to-read bypass, a per-register pending-load scoreboard with hazard stall, and a sequential clear engine that re-initialises all banks and latches new block metadata when a block is dispatched.

---
 rtl/banked_registers_if.sv | 37 +++
 rtl/banked_registers.sv | 157 +++++++++++++++
 tb/tb_banked_registers.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/banked_registers_if.sv
// Decoder-side bus of the per-core register file: dispatch metadata, read/write
// ports and the load scoreboard.
interface banked_registers_if #(
  parameter int DATA_BITS = 8,
  parameter int NUM_REGS  = 16,
  parameter int THREADS   = 4
);
  localparam int AW = $clog2(NUM_REGS);

  logic                         block_start;
  logic [7:0]                   block_id;
  logic [7:0]                   block_dim;
  logic                         busy;
  logic [AW-1:0]                rs_addr;
  logic [AW-1:0]                rt_addr;
  logic [THREADS*DATA_BITS-1:0] rs_data;
  logic [THREADS*DATA_BITS-1:0] rt_data;
  logic                         wr_en;
  logic [AW-1:0]                wr_addr;
  logic [THREADS-1:0]           wr_mask;
  logic [THREADS*DATA_BITS-1:0] wr_data;
  logic                         pend_set;
  logic [AW-1:0]                pend_addr;
  logic                         stall;

  modport master (
    output block_start, block_id, block_dim, rs_addr, rt_addr,
           wr_en, wr_addr, wr_mask, wr_data, pend_set, pend_addr,
    input  busy, rs_data, rt_data, stall
  );

  modport slave (
    input  block_start, block_id, block_dim, rs_addr, rt_addr,
           wr_en, wr_addr, wr_mask, wr_data, pend_set, pend_addr,
    output busy, rs_data, rt_data, stall
  );
endinterface

// File: rtl/banked_registers.sv
// Per-thread banked register file with masked writes, write-to-read bypass,
// pending-load scoreboard and a sequential clear engine run on block dispatch.
module banked_registers #(
  parameter int DATA_BITS = 8,
  parameter int NUM_REGS  = 16,
  parameter int THREADS   = 4,
  parameter int BYPASS    = 1
) (
  input logic               clk,
  input logic               reset,
  banked_registers_if.slave bus
);
  localparam int AW  = $clog2(NUM_REGS);
  localparam int NWR = NUM_REGS - 3;
  localparam logic [AW-1:0] ID_ADDR  = AW'(NUM_REGS - 3);
  localparam logic [AW-1:0] DIM_ADDR = AW'(NUM_REGS - 2);
  localparam logic [AW-1:0] LAST_WR  = AW'(NUM_REGS - 4);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  state_e               state_q;
  logic [AW-1:0]        idx_q;
  logic                 busy_q;
  logic [7:0]           id_q;
  logic [7:0]           dim_q;
  logic [DATA_BITS-1:0] regs_q [THREADS][NWR];
  logic [DATA_BITS-1:0] regs_d [THREADS][NWR];
  logic [NWR-1:0]       pending_q;
  logic [NWR-1:0]       pending_d;
  logic [NWR-1:0]       pend_clr_s;
  logic [NWR-1:0]       pend_set_s;
  logic                 wr_acc_s;
  logic                 stall_s;
  logic [AW-1:0]        raddr_s [2];
  logic [THREADS*DATA_BITS-1:0] rdata_s [2];

  function automatic logic pend_at(input logic [NWR-1:0] p, input logic [AW-1:0] a);
    return (a < ID_ADDR) ? p[a] : 1'b0;
  endfunction

  assign wr_acc_s = bus.wr_en & (bus.wr_addr < ID_ADDR) & ~busy_q;

  always_comb begin
    pend_clr_s = wr_acc_s ? ({{(NWR-1){1'b0}}, 1'b1} << bus.wr_addr) : '0;
    pend_set_s = (bus.pend_set & ~busy_q & (bus.pend_addr < ID_ADDR))
                 ? ({{(NWR-1){1'b0}}, 1'b1} << bus.pend_addr) : '0;
    // set is applied after clear so a load issued alongside its own return wins
    pending_d  = bus.block_start ? '0 : ((pending_q & ~pend_clr_s) | pend_set_s);
  end

  always_comb begin
    regs_d = regs_q;
    if (busy_q) begin
      for (int t = 0; t < THREADS; t++) begin
        regs_d[t][idx_q] = '0;
      end
    end else if (wr_acc_s) begin
      for (int t = 0; t < THREADS; t++) begin
        if (bus.wr_mask[t]) begin
          regs_d[t][bus.wr_addr] = bus.wr_data[t*DATA_BITS +: DATA_BITS];
        end else begin
          regs_d[t][bus.wr_addr] = regs_q[t][bus.wr_addr];
        end
      end
    end else begin
      regs_d = regs_q;
    end
  end

  always_comb begin
    logic [DATA_BITS-1:0] lane;
    lane = '0;
    raddr_s[0] = bus.rs_addr;
    raddr_s[1] = bus.rt_addr;
    rdata_s[0] = '0;
    rdata_s[1] = '0;
    for (int p = 0; p < 2; p++) begin
      for (int t = 0; t < THREADS; t++) begin
        if (raddr_s[p] < ID_ADDR) begin
          if ((BYPASS != 0) && wr_acc_s && (bus.wr_addr == raddr_s[p]) && bus.wr_mask[t]) begin
            lane = bus.wr_data[t*DATA_BITS +: DATA_BITS];
          end else begin
            lane = regs_q[t][raddr_s[p]];
          end
        end else if (raddr_s[p] == ID_ADDR) begin
          lane = DATA_BITS'(id_q);
        end else if (raddr_s[p] == DIM_ADDR) begin
          lane = DATA_BITS'(dim_q);
        end else begin
          lane = DATA_BITS'(t);
        end
        rdata_s[p][t*DATA_BITS +: DATA_BITS] = lane;
      end
    end
  end

  // A load return clears its own bit, so only the two read ports can hazard.
  assign stall_s     = ~busy_q & (pend_at(pending_q, bus.rs_addr) | pend_at(pending_q, bus.rt_addr));
  assign bus.stall   = stall_s;
  assign bus.busy    = busy_q;
  assign bus.rs_data = rdata_s[0];
  assign bus.rt_data = rdata_s[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int t = 0; t < THREADS; t++) begin
        for (int r = 0; r < NWR; r++) begin
          regs_q[t][r] <= '0;
        end
      end
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      id_q    <= 8'h00;
      dim_q   <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.block_start) begin
            id_q    <= bus.block_id;
            dim_q   <= bus.block_dim;
            idx_q   <= '0;
            state_q <= CLEAR;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (bus.block_start) begin
            id_q  <= bus.block_id;
            dim_q <= bus.block_dim;
            idx_q <= '0;
          end else if (idx_q == LAST_WR) begin
            idx_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_banked_registers.sv
// Directed bench for banked_registers: vector table for the read/write/scoreboard
// paths, hand-written sequences for clear, restart and mid-clear reset.
module tb_banked_registers;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cnt;

  banked_registers_if #(.DATA_BITS(8), .NUM_REGS(16), .THREADS(4)) bus();

  banked_registers #(.DATA_BITS(8), .NUM_REGS(16), .THREADS(4), .BYPASS(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic        we;
    logic [3:0]  wa;
    logic [3:0]  wm;
    logic [31:0] wd;
    logic        ps;
    logic [3:0]  pa;
    logic [31:0] ers;
    logic [31:0] ert;
    logic        est;
  } vec_t;

  localparam int NV = 21;
  localparam logic [31:0] TID = 32'h03020100;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [3:0] rs, input logic [3:0] rt, input logic we,
                              input logic [3:0] wa, input logic [3:0] wm, input logic [31:0] wd,
                              input logic ps, input logic [3:0] pa, input logic [31:0] ers,
                              input logic [31:0] ert, input logic est);
    vec_t v;
    v.rs = rs; v.rt = rt; v.we = we; v.wa = wa; v.wm = wm; v.wd = wd;
    v.ps = ps; v.pa = pa; v.ers = ers; v.ert = ert; v.est = est;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.block_start = 1'b0; bus.block_id = 8'h00; bus.block_dim = 8'h00;
    bus.rs_addr = 4'd0; bus.rt_addr = 4'd0;
    bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_mask = 4'h0; bus.wr_data = 32'h0;
    bus.pend_set = 1'b0; bus.pend_addr = 4'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
    bus.rs_addr = a;
    #2;
    chk(nm, bus.rs_data, e);
    tick();
  endtask

  task automatic fill_regs();
    for (int i = 0; i < 13; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 4'(i); bus.wr_mask = 4'hF;
      bus.wr_data = {4{8'(i + 1)}};
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    //           rs    rt    we    wa    wm    wd            ps    pa    ers           ert           st
    tbl[0]  = mk(4'd0, 4'd15,1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 32'h0,        TID,          1'b0);
    tbl[1]  = mk(4'd13,4'd14,1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 32'h0,        32'h0,        1'b0);
    tbl[2]  = mk(4'd12,4'd7, 1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 32'h0,        32'h0,        1'b0);
    tbl[3]  = mk(4'd3, 4'd4, 1'b1, 4'd3, 4'h5, 32'hDDCCBBAA, 1'b0, 4'd0, 32'h00CC00AA, 32'h0,        1'b0);
    tbl[4]  = mk(4'd3, 4'd15,1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 32'h00CC00AA, TID,          1'b0);
    tbl[5]  = mk(4'd14,4'd3, 1'b1, 4'd14,4'hF, 32'h11223344, 1'b0, 4'd0, 32'h0,        32'h00CC00AA, 1'b0);
    tbl[6]  = mk(4'd14,4'd0, 1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 32'h0,        32'h0,        1'b0);
    tbl[7]  = mk(4'd3, 4'd0, 1'b1, 4'd3, 4'hA, 32'h44332211, 1'b0, 4'd0, 32'h44CC22AA, 32'h0,        1'b0);
    tbl[8]  = mk(4'd5, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd5, 32'h0,        32'h0,        1'b0);
    tbl[9]  = mk(4'd5, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 32'h0,        32'h0,        1'b1);
    tbl[10] = mk(4'd0, 4'd5, 1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 32'h0,        32'h0,        1'b1);
    tbl[11] = mk(4'd0, 4'd0, 1'b1, 4'd5, 4'h1, 32'h000000EE, 1'b0, 4'd0, 32'h0,        32'h0,        1'b0);
    tbl[12] = mk(4'd5, 4'd3, 1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 32'h000000EE, 32'h44CC22AA, 1'b0);
    tbl[13] = mk(4'd0, 4'd0, 1'b1, 4'd5, 4'h0, 32'h0,        1'b1, 4'd5, 32'h0,        32'h0,        1'b0);
    tbl[14] = mk(4'd5, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 32'h000000EE, 32'h0,        1'b1);
    tbl[15] = mk(4'd1, 4'd2, 1'b1, 4'd5, 4'h0, 32'h0,        1'b0, 4'd0, 32'h0,        32'h0,        1'b0);
    tbl[16] = mk(4'd5, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 32'h000000EE, 32'h0,        1'b0);
    tbl[17] = mk(4'd12,4'd15,1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd12,32'h0,        TID,          1'b0);
    tbl[18] = mk(4'd13,4'd12,1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 32'h0,        32'h0,        1'b1);
    tbl[19] = mk(4'd0, 4'd0, 1'b1, 4'd12,4'h0, 32'h0,        1'b1, 4'd14,32'h0,        32'h0,        1'b0);
    tbl[20] = mk(4'd12,4'd14,1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 32'h0,        32'h0,        1'b0);

    idle_inputs();
    reset = 1'b0;
    bus.rt_addr = 4'd15;
    #2;
    chk("reset busy", {31'b0, bus.busy}, 32'h0);
    chk("reset stall", {31'b0, bus.stall}, 32'h0);
    chk("reset tid read", bus.rt_data, TID);
    #21 reset = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      bus.rs_addr = tbl[i].rs; bus.rt_addr = tbl[i].rt;
      bus.wr_en = tbl[i].we; bus.wr_addr = tbl[i].wa; bus.wr_mask = tbl[i].wm; bus.wr_data = tbl[i].wd;
      bus.pend_set = tbl[i].ps; bus.pend_addr = tbl[i].pa;
      #3;
      chk($sformatf("vec%0d rs_data", i), bus.rs_data, tbl[i].ers);
      chk($sformatf("vec%0d rt_data", i), bus.rt_data, tbl[i].ert);
      chk($sformatf("vec%0d stall", i), {31'b0, bus.stall}, {31'b0, tbl[i].est});
      tick();
    end
    idle_inputs();

    // Clear after a full fill, with writes and loads attempted while busy.
    fill_regs();
    bus.pend_set = 1'b1; bus.pend_addr = 4'd7;
    tick();
    bus.pend_set = 1'b0; bus.rs_addr = 4'd7;
    #2;
    chk("pend7 stall", {31'b0, bus.stall}, 32'h1);
    bus.block_start = 1'b1; bus.block_id = 8'd7; bus.block_dim = 8'd32;
    tick();
    bus.block_start = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_mask = 4'hF; bus.wr_data = 32'hFFFFFFFF;
    bus.pend_set = 1'b1; bus.pend_addr = 4'd2; bus.rt_addr = 4'd13;
    #2;
    chk("clear busy", {31'b0, bus.busy}, 32'h1);
    chk("clear stall forced", {31'b0, bus.stall}, 32'h0);
    chk("clear new id", bus.rt_data, 32'h07070707);
    #1;
    count_busy(cnt);
    idle_inputs();
    chk("clear busy cycles", 32'(cnt), 32'd13);
    for (int a = 0; a < 13; a++) rd(4'(a), 32'h0, $sformatf("cleared R%0d", a));
    rd(4'd13, 32'h07070707, "R13 id");
    rd(4'd14, 32'h20202020, "R14 dim");
    bus.rs_addr = 4'd7; bus.rt_addr = 4'd2;
    #2;
    chk("pending cleared", {31'b0, bus.stall}, 32'h0);
    tick();
    idle_inputs();

    // Second dispatch during clear cycle 6 restarts the sweep.
    fill_regs();
    bus.block_start = 1'b1; bus.block_id = 8'd7; bus.block_dim = 8'd32;
    tick();
    bus.block_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("restart still busy", {31'b0, bus.busy}, 32'h1);
    bus.block_start = 1'b1; bus.block_id = 8'd9; bus.block_dim = 8'd3;
    tick();
    bus.block_start = 1'b0;
    count_busy(cnt);
    chk("restart busy cycles", 32'(cnt), 32'd13);
    rd(4'd13, 32'h09090909, "restart R13");
    rd(4'd14, 32'h03030303, "restart R14");
    rd(4'd12, 32'h0, "restart R12");

    // Asynchronous reset in clear cycle 4.
    fill_regs();
    bus.block_start = 1'b1; bus.block_id = 8'd5; bus.block_dim = 8'd6;
    tick();
    bus.block_start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2 reset = 1'b0;
    #1;
    chk("async reset busy", {31'b0, bus.busy}, 32'h0);
    #3 reset = 1'b1;
    tick();
    for (int a = 0; a < 13; a++) rd(4'(a), 32'h0, $sformatf("post-reset R%0d", a));
    rd(4'd13, 32'h0, "post-reset R13");
    rd(4'd14, 32'h0, "post-reset R14");
    rd(4'd15, TID, "post-reset R15");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
